// File: rtl/light_sequencer_pkg.sv
// Shared definitions for the traffic light sequencer: phase codes, lamp
// encodings, default dwell times and the normal-cycle successor function.
package light_sequencer_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED_B = 3'd5,
        EMERG = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam int unsigned DEF_NBITS    = 16;
    localparam int unsigned DEF_GREEN_T  = 20;
    localparam int unsigned DEF_YELLOW_T = 3;
    localparam int unsigned DEF_ALLRED_T = 1;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            NS_G:    next_phase = NS_Y;
            NS_Y:    next_phase = RED_A;
            RED_A:   next_phase = EW_G;
            EW_G:    next_phase = EW_Y;
            EW_Y:    next_phase = RED_B;
            default: next_phase = NS_G;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input phase_e p);
        case (p)
            NS_G:    ns_lamp = LAMP_G;
            NS_Y:    ns_lamp = LAMP_Y;
            default: ns_lamp = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_e p);
        case (p)
            EW_G:    ew_lamp = LAMP_G;
            EW_Y:    ew_lamp = LAMP_Y;
            default: ew_lamp = LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/light_sequencer_phase_counter.sv
// Loadable NBITS down-counter holding the dwell time of the current phase.
// Priority: reset > load > decrement; never decrements below zero.
module phase_counter #(
    parameter int unsigned NBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] rst_val,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic             dec,
    output logic [NBITS-1:0] count,
    output logic             zero
);

    logic [NBITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= rst_val;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// Two-approach traffic light controller with demand-held greens and an
// emergency all-red override. Lamps are registered alongside the phase.
module light_sequencer
    import light_sequencer_pkg::*;
#(
    parameter int unsigned NBITS    = DEF_NBITS,
    parameter int unsigned GREEN_T  = DEF_GREEN_T,
    parameter int unsigned YELLOW_T = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T = DEF_ALLRED_T
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ns_req,
    input  logic             ew_req,
    input  logic             emerg,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic [NBITS-1:0] remaining
);

    if (((GREEN_T >> NBITS) != 0) || ((YELLOW_T >> NBITS) != 0) ||
        ((ALLRED_T >> NBITS) != 0)) begin : g_bad_dwell
        $error("light_sequencer: dwell load value does not fit in NBITS");
    end

    phase_e           state_q, state_d;
    logic [2:0]       ns_light_q, ns_light_d;
    logic [2:0]       ew_light_q, ew_light_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [NBITS-1:0] cnt_load_val, cnt_val;

    function automatic logic [NBITS-1:0] dwell_of(input phase_e p);
        case (p)
            NS_G, EW_G:   dwell_of = NBITS'(GREEN_T);
            NS_Y, EW_Y:   dwell_of = NBITS'(YELLOW_T);
            RED_A, RED_B: dwell_of = NBITS'(ALLRED_T);
            default:      dwell_of = '0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (emerg) begin
            state_d  = EMERG;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                NS_G, NS_Y, RED_A, EW_G, EW_Y, RED_B: begin
                    if (tick) begin
                        if (!cnt_zero) begin
                            cnt_dec = 1'b1;
                        // An expired green waits at zero until the cross street asks.
                        end else if (!((state_q == NS_G && !ew_req) ||
                                       (state_q == EW_G && !ns_req))) begin
                            state_d  = next_phase(state_q);
                            cnt_load = 1'b1;
                        end
                    end
                end
                default: begin
                    // EMERG exit and illegal codes both land in RED_B immediately.
                    state_d  = RED_B;
                    cnt_load = 1'b1;
                end
            endcase
        end
        cnt_load_val = dwell_of(state_d);
        ns_light_d   = ns_lamp(state_d);
        ew_light_d   = ew_lamp(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RED_B;
            ns_light_q <= LAMP_R;
            ew_light_q <= LAMP_R;
        end else begin
            state_q    <= state_d;
            ns_light_q <= ns_light_d;
            ew_light_q <= ew_light_d;
        end
    end

    phase_counter #(.NBITS(NBITS)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .rst_val  (NBITS'(ALLRED_T)),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    assign phase     = state_q;
    assign remaining = cnt_val;
    assign ns_light  = ns_light_q;
    assign ew_light  = ew_light_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench: stimulus steps a rule-level model and queues the expected
// phase/remaining; a monitor pops one entry per cycle and compares.
module tb_light_sequencer;

    localparam int NB = 4;
    localparam int GT = 3;
    localparam int YT = 1;
    localparam int AT = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1, tick = 1'b0, ns_req = 1'b0, ew_req = 1'b0, emerg = 1'b0;
    logic [2:0]    ns_light, ew_light, phase;
    logic [NB-1:0] remaining;

    always #5 clk = ~clk;

    light_sequencer #(.NBITS(NB), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .ns_req    (ns_req),
        .ew_req    (ew_req),
        .emerg     (emerg),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .phase     (phase),
        .remaining (remaining)
    );

    typedef struct {
        int ph;
        int rem;
    } exp_t;

    exp_t sb[$];
    int   m_ph  = 5;
    int   m_rem = AT;
    int   n_vec = 0;
    int   n_err = 0;

    // phase index: 0 NS green, 1 NS yellow, 2 red, 3 EW green, 4 EW yellow, 5 red, 6 emergency
    function automatic int dwell(input int p);
        if (p == 0 || p == 3) return GT;
        if (p == 1 || p == 4) return YT;
        if (p == 2 || p == 5) return AT;
        return 0;
    endfunction

    function automatic logic [2:0] ns_of(input int p);
        if (p == 0) return 3'b001;
        if (p == 1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ew_of(input int p);
        if (p == 3) return 3'b001;
        if (p == 4) return 3'b010;
        return 3'b100;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic t,
                              input logic n, input logic w);
        if (r) begin
            m_ph = 5; m_rem = AT;
        end else if (e) begin
            m_ph = 6; m_rem = 0;
        end else if (m_ph == 6) begin
            m_ph = 5; m_rem = AT;
        end else if (t) begin
            if (m_rem > 0)
                m_rem = m_rem - 1;
            else if (!((m_ph == 0 && !w) || (m_ph == 3 && !n))) begin
                m_ph  = (m_ph + 1) % 6;
                m_rem = dwell(m_ph);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic t,
                       input logic n, input logic w);
        exp_t x;
        @(negedge clk);
        reset = r; emerg = e; tick = t; ns_req = n; ew_req = w;
        model_step(r, e, t, n, w);
        x.ph = m_ph; x.rem = m_rem;
        sb.push_back(x);
    endtask

    task automatic reach_fail(input string what);
        n_vec++;
        n_err++;
        $display("FAIL reach_%s: model phase=%0d rem=%0d, target not reached", what, m_ph, m_rem);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                n_vec++;
                if (phase !== 3'(x.ph) || remaining !== NB'(x.rem) ||
                    ns_light !== ns_of(x.ph) || ew_light !== ew_of(x.ph)) begin
                    n_err++;
                    $display("FAIL vec%0d: got phase=%0d rem=%0d ns=%b ew=%b, want phase=%0d rem=%0d ns=%b ew=%b",
                             n_vec, phase, remaining, ns_light, ew_light,
                             x.ph, x.rem, ns_of(x.ph), ew_of(x.ph));
                end
                n_vec++;
                if ((ns_light !== 3'b100 && ew_light !== 3'b100) || phase > 3'd6) begin
                    n_err++;
                    $display("FAIL safety: got ns=%b ew=%b phase=%0d, want one side red and phase<=6",
                             ns_light, ew_light, phase);
                end
            end
        end
    end

    initial begin : stim
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1);

        // full cycle with both approaches requesting
        repeat (18) cyc(0, 0, 1, 1, 1);

        // green hold while EW has no demand, then release
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && !(m_ph == 0 && m_rem == 0); i++) cyc(0, 0, 1, 1, 0);
        if (!(m_ph == 0 && m_rem == 0)) reach_fail("ns_expiry");
        repeat (5) cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        repeat (4) cyc(0, 0, 1, 1, 1);

        // slow timebase
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 64; i++) cyc(0, 0, (i % 4) == 3, 1, 1);

        // emergency during EW green with two ticks left
        cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 60 && !(m_ph == 3 && m_rem == 2); i++) cyc(0, 0, 1, 1, 1);
        if (!(m_ph == 3 && m_rem == 2)) reach_fail("ew_green_2");
        cyc(0, 1, 1, 1, 1);
        cyc(0, 1, 0, 1, 1);
        repeat (8) cyc(0, 0, 1, 1, 1);

        // reset wins over emerg and tick in EW yellow
        for (int i = 0; i < 60 && m_ph != 4; i++) cyc(0, 0, 1, 1, 1);
        if (m_ph != 4) reach_fail("ew_yellow");
        cyc(1, 1, 1, 1, 1);
        cyc(0, 0, 0, 1, 1);

        // random run; emergency comes in short bursts
        begin
            int eburst = 0;
            for (int i = 0; i < 3000; i++) begin
                if (eburst == 0 && $urandom_range(0, 40) == 0) eburst = $urandom_range(1, 4);
                cyc($urandom_range(0, 199) == 0, eburst != 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
                if (eburst != 0) eburst--;
            end
        end

        @(posedge clk);
        #4;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter NBITS, default 16, width of the dwell counter and the remaining output.
REQ-002 Parameter GREEN_T, default 20, green dwell load value in ticks.
REQ-003 Parameter YELLOW_T, default 3, yellow dwell load value in ticks.
REQ-004 Parameter ALLRED_T, default 1, all-red dwell load value in ticks.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset; sampled on posedge clk only.
REQ-007 tick  input  1  one-cycle timebase enable; the counter advances only when tick=1.
REQ-008 ns_req  input  1  vehicle present on the north/south approach, level.
REQ-009 ew_req  input  1  vehicle present on the east/west approach, level.
REQ-010 emerg  input  1  emergency override, level; forces all-red.
REQ-011 ns_light  output  3  {R,Y,G} one-hot north/south lamps.
REQ-012 ew_light  output  3  {R,Y,G} one-hot east/west lamps.
REQ-013 phase  output  3  current state code.
REQ-014 remaining  output  NBITS  current dwell counter value.

Function
REQ-015 States: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, EMERG=6. All other codes are illegal and go to RED_B with ALLRED_T loaded.
REQ-016 Normal cycle: NS_G->NS_Y->RED_A->EW_G->EW_Y->RED_B->NS_G.
REQ-017 Lamps: NS_G gives ns=G, ew=R. NS_Y gives ns=Y, ew=R. EW_G gives ns=R, ew=G. EW_Y gives ns=R, ew=Y. RED_A, RED_B and EMERG give both=R.
REQ-018 Lamps are registered and decoded from the state register; they never show G or Y on both approaches in the same cycle.
REQ-019 On entry to a state, remaining loads that state's parameter: G states load GREEN_T, Y states load YELLOW_T, RED states load ALLRED_T, EMERG loads 0.
REQ-020 When tick=1 and remaining!=0, remaining decrements by 1 and the state holds.
REQ-021 When tick=1 and remaining==0, the state advances and the next state's value loads in the same edge. Dwell is therefore load+1 ticks.
REQ-022 When tick=0, state and remaining hold.
REQ-023 Green hold: in NS_G with remaining==0, tick=1 and ew_req=0, the state stays NS_G and remaining stays 0. EW_G behaves the same way, using ns_req.
REQ-024 Requests are only evaluated at the green expiry edge; they have no effect at any other point.
REQ-025 emerg=1 moves the state to EMERG on the next edge regardless of tick or state, with remaining=0. Both lamps are R from that edge onward.
REQ-026 While emerg=1 the state stays EMERG.
REQ-027 On the first edge with emerg=0 in EMERG, the state goes to RED_B with ALLRED_T loaded. Exit does not need tick.
REQ-028 Priority: reset > emerg > tick expiry > tick decrement > hold.
REQ-029 Counter arithmetic is unsigned NBITS with no wrap. Load values wider than NBITS are a parameter error, checked at elaboration.

Reset
REQ-030 reset=1 at an edge sets state=RED_B, remaining=ALLRED_T, ns_light=R, ew_light=R and phase=5 on that edge.
REQ-031 Reset mid-dwell discards all count and state; the first green after reset is NS_G.
REQ-032 reset overrides emerg and tick in the same cycle.

Structure
REQ-033 A shared package holds the state codes, the lamp encodings (R=3'b100, Y=3'b010, G=3'b001) and the default dwell constants.
REQ-034 One sub-module, phase_counter, holds the loadable down-counter (load value, load enable, decrement enable, synchronous reset value) and flags zero.
REQ-035 The top level contains the state register, next-state logic and lamp decode.

Verification (GREEN_T=3, YELLOW_T=1, ALLRED_T=1, NBITS=4)
REQ-036 Reset, then ns_req=ew_req=1 with tick every cycle -> phase sequence 5,5,0,0,0,0,1,1,2,2,3,3,3,3,4,4,5,5,0.
REQ-037 In NS_G, ew_req=0 at expiry with 5 further ticks -> phase stays 0 and remaining stays 0. Raise ew_req -> NS_Y on the next tick.
REQ-038 tick asserted once every 4 cycles -> remaining changes only on tick cycles; NS_G lasts 16 cycles.
REQ-039 emerg pulsed 2 cycles during EW_G with remaining=2 -> both lamps R for 2 cycles (phase=6), then RED_B with remaining=1, then NS_G.
REQ-040 reset asserted together with emerg and tick in EW_Y -> next phase=5, remaining=1, both lamps R.
REQ-041 Every cycle of a random run -> never G/Y on both approaches at once, and phase is always in 0..6.
